uart_rx: RTL and testbench

// - UART receiver. Converts the serial line into parallel bytes, LSB first, format 8N1 by default.
// - Sits directly downstream of the baud tick generator. Its baud tick input must run at

---
 rtl/uart_rx.sv | 136 +++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized serial input, oversampled start/data/stop
// detection, LSB-first shift register, one-clock completion pulse with framing status.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int SB_TICKS   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_err
);

    localparam int SMAX = (OVERSAMPLE > SB_TICKS) ? OVERSAMPLE : SB_TICKS;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE/2 - 1);
    localparam logic [SW-1:0] S_BIT  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICKS - 1);
    localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t                r_state, w_state_nx;
    logic [SW-1:0]         r_s, w_s_nx;
    logic [NW-1:0]         r_n, w_n_nx;
    logic [DATA_BITS-1:0]  r_shreg, w_shreg_nx;
    logic [DATA_BITS-1:0]  r_data, w_data_nx;
    logic                  r_done, w_done_nx;
    logic                  r_ferr, w_ferr_nx;
    logic                  r_rx_meta, r_rx_s, r_tick_d;
    logic                  w_tk;

    // Line synchronizer and tick edge detect; both load the idle level so reset
    // never looks like a start bit or a fresh tick.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_tick_d  <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_s    <= r_rx_meta;
            r_tick_d  <= i_tick;
        end
    end

    // A tick held high for several clocks counts once.
    assign w_tk = i_tick & ~r_tick_d;

    // State, counters, shift register and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_shreg <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_s     <= w_s_nx;
            r_n     <= w_n_nx;
            r_shreg <= w_shreg_nx;
            r_data  <= w_data_nx;
            r_done  <= w_done_nx;
            r_ferr  <= w_ferr_nx;
        end
    end

    // Next-state and datapath: start is confirmed at mid-bit, data sampled every
    // full bit after that, stop sampled at the last of its ticks.
    always_comb begin
        w_state_nx = r_state;
        w_s_nx     = r_s;
        w_n_nx     = r_n;
        w_shreg_nx = r_shreg;
        w_data_nx  = r_data;
        w_ferr_nx  = r_ferr;
        w_done_nx  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!r_rx_s) begin
                    w_state_nx = START;
                    w_s_nx     = '0;
                end
            end
            START: begin
                if (w_tk) begin
                    if (r_s == S_HALF) begin
                        w_s_nx = '0;
                        w_n_nx = '0;
                        w_state_nx = r_rx_s ? IDLE : DATA;
                    end else begin
                        w_s_nx = r_s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (w_tk) begin
                    if (r_s == S_BIT) begin
                        w_s_nx     = '0;
                        w_shreg_nx = {r_rx_s, r_shreg[DATA_BITS-1:1]};
                        if (r_n == N_LAST) w_state_nx = STOP;
                        else               w_n_nx     = r_n + NW'(1);
                    end else begin
                        w_s_nx = r_s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (w_tk) begin
                    if (r_s == S_STOP) begin
                        w_data_nx  = r_shreg;
                        w_ferr_nx  = ~r_rx_s;
                        w_done_nx  = 1'b1;
                        w_state_nx = IDLE;
                    end else begin
                        w_s_nx = r_s + SW'(1);
                    end
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    assign o_data      = r_data;
    assign o_rx_done   = r_done;
    assign o_frame_err = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frames are sent tick-aligned, expected words and completion
// latency go into a scoreboard, and a monitor pops/compares on each o_rx_done.
module tb_uart_rx;

    localparam int BIT_CLK = 256;                  // 16 ticks * 16 clk
    localparam int LAT     = 1 + 16 * (8 + 16*8 + 16); // tick-aligned start edge -> done

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_tick = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data;
    logic       o_rx_done;
    logic       o_frame_err;

    uart_rx dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_tick(i_tick), .i_rx(i_rx),
        .o_data(o_data), .o_rx_done(o_rx_done), .o_frame_err(o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    // Tick generator: one tick period every 16 clocks, high for tick_w clocks.
    int ph = 15;
    int tick_w = 1;
    initial forever begin
        @(posedge i_clk); #1;
        ph = (ph == 15) ? 0 : ph + 1;
        i_tick = (ph < tick_w);
    end

    typedef struct {
        logic [7:0] d;
        logic       fe;
        int         t0;
        int         lat;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic [7:0] exp_d;
        logic       exp_fe;
    } vec_t;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: every completion pops one expectation; pulse must be one clock.
    initial begin
        bit chk_w = 0;
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (chk_w) begin
                check("pulse_width", int'(o_rx_done), 0);
                chk_w = 0;
            end else if (o_rx_done) begin
                chk_w = 1;
                if (sb.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("data", int'(o_data), int'(e.d));
                    check("frame_err", int'(o_frame_err), int'(e.fe));
                    check("latency", cyc - e.t0, e.lat);
                end
            end
        end
    end

    task automatic bt(input int n);
        repeat (n) @(posedge i_clk);
        #2;
    endtask

    // Wait until the tick was just raised, so frame timing is deterministic.
    task automatic align();
        do begin
            @(posedge i_clk); #2;
        end while (ph != 0);
    endtask

    // One 10-bit frame, 2560 clocks long; a low stop bit is released shortly after
    // its sample point so the line does not look like a break afterwards.
    task automatic send_frame(input logic [7:0] d, input logic stop);
        i_rx = 1'b0;
        bt(BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            i_rx = d[i];
            bt(BIT_CLK);
        end
        i_rx = stop;
        if (stop) begin
            bt(BIT_CLK);
        end else begin
            bt(136);
            i_rx = 1'b1;
            bt(BIT_CLK - 136);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic fe, input int lat);
        exp_t e;
        e.d = d; e.fe = fe; e.t0 = cyc; e.lat = lat;
        sb.push_back(e);
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{8'hA5, 1'b1, 8'hA5, 1'b0};
        vt[1] = '{8'h3C, 1'b0, 8'h3C, 1'b1};
        vt[2] = '{8'h00, 1'b1, 8'h00, 1'b0};
        vt[3] = '{8'hFF, 1'b1, 8'hFF, 1'b0};
        vt[4] = '{8'h01, 1'b1, 8'h01, 1'b0};
        vt[5] = '{8'h7E, 1'b0, 8'h7E, 1'b1};

        bt(5);
        check("rst_data", int'(o_data), 0);
        check("rst_done", int'(o_rx_done), 0);
        check("rst_ferr", int'(o_frame_err), 0);
        i_rst_n = 1'b1;
        bt(40);

        // Table-driven frames, each followed by an idle gap.
        for (int k = 0; k < 6; k++) begin
            align();
            push(vt[k].exp_d, vt[k].exp_fe, LAT);
            send_frame(vt[k].d, vt[k].stop);
            bt(512);
        end
        check("queue_drained_table", sb.size(), 0);

        // Glitch: 4 ticks low then high -> false start, outputs untouched.
        align();
        i_rx = 1'b0;
        bt(64);
        i_rx = 1'b1;
        bt(1000);
        check("glitch_data_held", int'(o_data), 8'h7E);
        check("glitch_ferr_held", int'(o_frame_err), 1);

        // Reset after data bit 3: frame aborted silently, outputs cleared.
        align();
        i_rx = 1'b0;
        bt(BIT_CLK * 5);
        i_rst_n = 1'b0;
        bt(1);
        i_rst_n = 1'b1;
        i_rx = 1'b1;
        bt(3000);
        check("midrst_data", int'(o_data), 0);
        check("midrst_ferr", int'(o_frame_err), 0);
        align();
        push(8'h5A, 1'b0, LAT);
        send_frame(8'h5A, 1'b1);
        bt(512);

        // Back-to-back frames with no idle gap.
        align();
        push(8'h00, 1'b0, LAT);
        send_frame(8'h00, 1'b1);
        push(8'hFF, 1'b0, LAT);
        send_frame(8'hFF, 1'b1);
        push(8'h81, 1'b0, LAT);
        send_frame(8'h81, 1'b1);
        bt(512);
        check("queue_drained_b2b", sb.size(), 0);

        // Wide ticks: same completion latency as single-clock ticks.
        tick_w = 4;
        align();
        push(8'hC3, 1'b0, LAT);
        send_frame(8'hC3, 1'b1);
        bt(512);
        tick_w = 1;

        // Break: line held low gives two zero frames with framing error, the second
        // restarting from IDLE right after the first completes.
        align();
        push(8'h00, 1'b1, LAT);
        push(8'h00, 1'b1, LAT + 16 * (8 + 16*8 + 16));
        i_rx = 1'b0;
        bt(4900);
        i_rx = 1'b1;
        bt(3000);

        check("queue_drained_end", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
